// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a dump engine.
//
// Purpose:
//   Holds NREGS registers of XLEN bits each. It has NREAD combinational read
//   ports and NWRITE write ports, which take effect on the rising clock edge.
//   Register 0 always reads zero. When BYPASS=1, a read of a register that is
//   being written in the same cycle returns the write data. A sequential dump
//   engine streams every register over a valid/ready port.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   read_id     NREAD x IDW read indices
//   read_data   NREAD x XLEN read data (combinational)
//   write_en    NWRITE per-port write enables
//   write_id    NWRITE x IDW write indices
//   write_data  NWRITE x XLEN write data
//   dump_start  request a full dump (sampled only while idle)
//   dump_valid  dump beat valid
//   dump_ready  consumer accepts the current beat
//   dump_idx    index of the current dump beat
//   dump_data   value of register dump_idx
//   dump_busy   dump engine active (SEND or DONE)
//   dump_done   one-cycle pulse after the last beat is accepted
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1,
   parameter int BYPASS = 1,
   localparam int IDW   = $clog2(NREGS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NREAD-1:0][IDW-1:0]         read_id,
   output logic [NREAD-1:0][XLEN-1:0]        read_data,
   input  logic [NWRITE-1:0]                 write_en,
   input  logic [NWRITE-1:0][IDW-1:0]        write_id,
   input  logic [NWRITE-1:0][XLEN-1:0]       write_data,
   input  logic                              dump_start,
   output logic                              dump_valid,
   input  logic                              dump_ready,
   output logic [IDW-1:0]                    dump_idx,
   output logic [XLEN-1:0]                   dump_data,
   output logic                              dump_busy,
   output logic                              dump_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_t;

   logic [XLEN-1:0] regs_reg  [NREGS];
   logic [XLEN-1:0] regs_next [NREGS];

   // Write ports are applied in ascending order, so the higher-numbered
   // port wins when two ports target the same register. Index 0 is never
   // written, which keeps register 0 at its reset value of zero.
   always_comb begin
      regs_next = regs_reg;
      for (int p = 0; p < NWRITE; p++) begin
         if (write_en[p] && (write_id[p] != '0)) begin
            regs_next[write_id[p]] = write_data[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= regs_next[i];
         end
      end
   end

   // Read ports: the stored value, optionally overridden by a same-cycle
   // write to the same index (last port wins). Index 0 always returns zero.
   genvar gi;
   generate
      for (gi = 0; gi < NREAD; gi++) begin : g_read
         logic [XLEN-1:0] rd_value;

         always_comb begin
            rd_value = regs_reg[read_id[gi]];
            if (BYPASS != 0) begin
               for (int p = 0; p < NWRITE; p++) begin
                  if (write_en[p] && (write_id[p] == read_id[gi])) begin
                     rd_value = write_data[p];
                  end
               end
            end
            if (read_id[gi] == '0) begin
               rd_value = '0;
            end
         end

         assign read_data[gi] = rd_value;
      end
   endgenerate

   // Dump engine.
   dump_state_t    state_reg;
   logic [IDW-1:0] idx_reg;
   logic           valid_reg;
   logic           busy_reg;
   logic           done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (dump_start) begin
                  state_reg <= SEND;
                  idx_reg   <= '0;
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            SEND: begin
               if (dump_ready) begin
                  if (idx_reg == IDW'(NREGS - 1)) begin
                     state_reg <= DONE;
                     idx_reg   <= '0;
                     valid_reg <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     idx_reg <= idx_reg + IDW'(1);
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               idx_reg   <= '0;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Dump data reads the stored register directly (never bypassed), so a
   // write landing on a stalled beat's register shows up on the next cycle.
   // Register 0 is held at zero, so beat 0 is zero without special casing.
   assign dump_valid = valid_reg;
   assign dump_idx   = idx_reg;
   assign dump_data  = valid_reg ? regs_reg[idx_reg] : '0;
   assign dump_busy  = busy_reg;
   assign dump_done  = done_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Main instance: NWRITE=2, BYPASS=1. Side instance: NWRITE=1, BYPASS=0.
// Dump beats are checked against a scoreboard queue filled from a register
// model when each dump is requested.
module tb_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int IDW   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][IDW-1:0]  rid;
   logic [1:0][XLEN-1:0] rdata;
   logic [1:0]           we;
   logic [1:0][IDW-1:0]  wid;
   logic [1:0][XLEN-1:0] wdata;
   logic                 dump_start, dump_valid, dump_ready, dump_busy, dump_done;
   logic [IDW-1:0]       dump_idx;
   logic [XLEN-1:0]      dump_data;

   logic [1:0][IDW-1:0]  b_rid;
   logic [1:0][XLEN-1:0] b_rdata;
   logic [0:0]           b_we;
   logic [0:0][IDW-1:0]  b_wid;
   logic [0:0][XLEN-1:0] b_wdata;
   logic                 b_dump_start, b_dump_valid, b_dump_ready, b_dump_busy, b_dump_done;
   logic [IDW-1:0]       b_dump_idx;
   logic [XLEN-1:0]      b_dump_data;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .read_id(rid), .read_data(rdata),
      .write_en(we), .write_id(wid), .write_data(wdata),
      .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
   );

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .NWRITE(1), .BYPASS(0)) u_nobyp (
      .clk(clk), .rst_n(rst_n),
      .read_id(b_rid), .read_data(b_rdata),
      .write_en(b_we), .write_id(b_wid), .write_data(b_wdata),
      .dump_start(b_dump_start), .dump_valid(b_dump_valid), .dump_ready(b_dump_ready),
      .dump_idx(b_dump_idx), .dump_data(b_dump_data), .dump_busy(b_dump_busy), .dump_done(b_dump_done)
   );

   typedef struct packed {
      logic [IDW-1:0]  idx;
      logic [XLEN-1:0] data;
   } beat_t;

   beat_t           exp_q[$];
   logic [XLEN-1:0] model [NREGS];
   int              n_checks = 0;
   int              n_errors = 0;
   int              dc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_dump();
      beat_t b;
      for (int i = 0; i < NREGS; i++) begin
         b.idx  = IDW'(i);
         b.data = model[i];
         exp_q.push_back(b);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NREGS; i++) model[i] = '0;
   endtask

   // Runs one dump whose dump_start was already driven on the previous
   // negedge. Cycle c=1 is the first cycle after dump_start is sampled.
   task automatic run_dump(input int stall_beat, input int stall_len, input int pulse_at,
                           input bit hold_start, output int done_cycle);
      int    accepted;
      int    stalled;
      beat_t e;
      accepted   = 0;
      stalled    = 0;
      done_cycle = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         dump_start = hold_start || (c == pulse_at);
         dump_ready = !((accepted == stall_beat) && (stalled < stall_len));
         #1;
         if (dump_done) begin
            done_cycle = c;
            check("done_valid_low", dump_valid, 0);
            check("done_busy", dump_busy, 1);
            check("beats_left", exp_q.size(), 0);
            $display("dump done at cycle %0d after %0d beats", c, accepted);
            break;
         end
         if (dump_valid) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", exp_q.size(), 1);
               break;
            end
            e = exp_q[0];
            check("beat_idx", dump_idx, e.idx);
            check("beat_data", dump_data, e.data);
            check("beat_busy", dump_busy, 1);
            if (dump_ready) begin
               void'(exp_q.pop_front());
               accepted++;
               $display("beat idx=%0d data=0x%0h", dump_idx, dump_data);
            end else begin
               stalled++;
               $display("stall idx=%0d data=0x%0h", dump_idx, dump_data);
            end
         end
      end
      if (done_cycle < 0) check("dump_timeout", done_cycle, NREGS + 1);
   endtask

   initial begin
      rid = '0; we = '0; wid = '0; wdata = '0;
      dump_start = 0; dump_ready = 0;
      b_rid = '0; b_we = '0; b_wid = '0; b_wdata = '0;
      b_dump_start = 0; b_dump_ready = 0;
      clear_model();

      // Reset state
      rid[0] = 5; rid[1] = 31;
      #2;
      check("rst_rd0", rdata[0], 0);
      check("rst_rd1", rdata[1], 0);
      check("rst_valid", dump_valid, 0);
      check("rst_busy", dump_busy, 0);
      check("rst_done", dump_done, 0);
      check("rst_idx", dump_idx, 0);
      check("rst_data", dump_data, 0);
      @(negedge clk); rst_n = 1;

      // Basic write then read
      @(negedge clk); we = 2'b01; wid[0] = 5; wdata[0] = 32'hDEADBEEF; rid[0] = 0;
      model[5] = 32'hDEADBEEF;
      $display("write x5=0xdeadbeef");
      @(negedge clk); we = '0; rid[0] = 5; #1;
      check("x5_read", rdata[0], model[5]);

      // x0 hardwire
      @(negedge clk); we = 2'b01; wid[0] = 0; wdata[0] = 32'hFFFFFFFF; rid[0] = 0; rid[1] = 0; #1;
      $display("write x0=0xffffffff");
      check("x0_same_p0", rdata[0], 0);
      check("x0_same_p1", rdata[1], 0);
      @(negedge clk); we = '0; #1;
      check("x0_next_p0", rdata[0], 0);
      check("x0_next_p1", rdata[1], 0);

      // Bypass vs no bypass
      @(negedge clk); we = 2'b01; wid[0] = 7; wdata[0] = 32'h12345678; rid[0] = 7;
      b_we = 1'b1; b_wid[0] = 7; b_wdata[0] = 32'h12345678; b_rid[0] = 7; #1;
      $display("write x7=0x12345678 with same-cycle read");
      check("bypass_on", rdata[0], 32'h12345678);
      check("bypass_off", b_rdata[0], 0);
      model[7] = 32'h12345678;
      @(negedge clk); we = '0; b_we = '0; #1;
      check("x7_after_on", rdata[0], model[7]);
      check("x7_after_off", b_rdata[0], 32'h12345678);

      // Two write ports to the same register: port 1 wins
      @(negedge clk); we = 2'b11; wid[0] = 3; wid[1] = 3; wdata[0] = 32'h11; wdata[1] = 32'h22; rid[1] = 3; #1;
      $display("write x3 port0=0x11 port1=0x22");
      check("conflict_bypass", rdata[1], 32'h22);
      model[3] = 32'h22;
      @(negedge clk); we = '0; #1;
      check("conflict_stored", rdata[1], model[3]);

      // Asynchronous reset mid-cycle clears reads with no clock edge
      @(negedge clk); rid[0] = 5; rid[1] = 3; b_rid[0] = 7;
      #2 rst_n = 0;
      #1;
      check("async_rst_rd0", rdata[0], 0);
      check("async_rst_rd1", rdata[1], 0);
      check("async_rst_b", b_rdata[0], 0);
      @(negedge clk); rst_n = 1;
      clear_model();

      // Preload xi = i*4 using both ports
      for (int i = 1; i < NREGS; i += 2) begin
         @(negedge clk);
         we[0] = 1'b1; wid[0] = IDW'(i); wdata[0] = XLEN'(i * 4); model[i] = XLEN'(i * 4);
         if (i + 1 < NREGS) begin
            we[1] = 1'b1; wid[1] = IDW'(i + 1); wdata[1] = XLEN'((i + 1) * 4);
            model[i + 1] = XLEN'((i + 1) * 4);
         end else begin
            we[1] = 1'b0;
         end
         $display("preload x%0d and x%0d", i, i + 1);
      end
      @(negedge clk); we = '0; rid[0] = 31; #1;
      check("preload_x31", rdata[0], model[31]);

      // Dump with 3 cycles of backpressure on beat 2
      push_dump();
      @(negedge clk); dump_start = 1; dump_ready = 1;
      run_dump(2, 3, 0, 0, dc);
      check("stall_done_cycle", dc, NREGS + 1 + 3);
      @(negedge clk); dump_start = 0; #1;
      check("post_busy", dump_busy, 0);
      check("post_done", dump_done, 0);
      check("post_valid", dump_valid, 0);

      // Timing with ready high; a start pulse during SEND is ignored
      push_dump();
      @(negedge clk); dump_start = 1; dump_ready = 1;
      run_dump(-1, 0, 5, 0, dc);
      check("dump_cycles", dc, NREGS + 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); dump_start = 0; #1;
         check("no_restart", dump_valid, 0);
      end

      // dump_start held high retriggers after DONE
      push_dump();
      @(negedge clk); dump_start = 1; dump_ready = 1;
      run_dump(-1, 0, 0, 1, dc);
      check("hold_dump_cycles", dc, NREGS + 1);
      push_dump();
      @(negedge clk); #1;
      check("retrig_idle_valid", dump_valid, 0);
      check("retrig_idle_busy", dump_busy, 0);
      run_dump(-1, 0, 0, 0, dc);
      check("retrig_cycles", dc, NREGS + 1);

      // Reset in the middle of a dump
      @(negedge clk); dump_start = 1; dump_ready = 1; rid[0] = 5;
      dc = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk); dump_start = 0; #1;
         if (dump_valid && dump_idx == 10) begin
            dc = c;
            break;
         end
      end
      check("mid_reached_idx", dc, 11);
      #1 rst_n = 0;
      #1;
      $display("reset asserted during dump beat %0d", dump_idx);
      check("mid_rst_valid", dump_valid, 0);
      check("mid_rst_busy", dump_busy, 0);
      check("mid_rst_done", dump_done, 0);
      check("mid_rst_reg", rdata[0], 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("mid_rst_no_done", dump_done, 0);
      end
      @(negedge clk); rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("after_rst_no_done", dump_done, 0);
         check("after_rst_no_valid", dump_valid, 0);
      end
      exp_q.delete();
      clear_model();

      // Fresh dump streams all zeros
      push_dump();
      @(negedge clk); dump_start = 1; dump_ready = 1;
      run_dump(-1, 0, 0, 0, dc);
      check("zero_dump_cycles", dc, NREGS + 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
